// File: rtl/acc_adder_tree.sv
// acc_adder_tree: pipelined N-lane reduction tree with packet accumulation.
// Each accepted beat is extended to OW bits and summed pairwise over
// STAGES register levels. The final stage folds tree sums into an
// accumulator and emits one result per packet, on the beat tagged last.
// A single global enable freezes the whole pipe under back-pressure.
module acc_adder_tree #(
    parameter int N      = 81,
    parameter int W      = 32,
    parameter int OW     = 48,
    parameter bit SIGNED = 1'b1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [W-1:0]  in_i [0:N-1],
    input  logic          valid_i,
    input  logic          first_i,
    input  logic          last_i,
    output logic          ready_o,
    output logic [OW-1:0] out_o,
    output logic          valid_o,
    input  logic          ready_i
);

    // A single lane still gets one register level so the timing is uniform.
    localparam int STAGES = (N > 1) ? $clog2(N) : 1;

    // Number of nodes on tree level k (level 0 is the extended lane input).
    function automatic int lvl_cnt(input int k);
        return (N + (1 << k) - 1) >> k;
    endfunction

    // Offset of level k (k >= 1) inside the flat node storage.
    function automatic int lvl_ofs(input int k);
        int s;
        s = 0;
        for (int j = 1; j < k; j++) begin
            s = s + lvl_cnt(j);
        end
        return s;
    endfunction

    localparam int TOTAL = lvl_ofs(STAGES + 1);
    localparam int ROOT  = lvl_ofs(STAGES);

    genvar gi, gj;

    logic          en;
    logic [OW-1:0] lane_ext [0:N-1];
    logic [OW-1:0] node_q   [0:TOTAL-1];
    logic [STAGES:1] vld_q;
    logic [STAGES:1] first_q;
    logic [STAGES:1] last_q;

    logic [OW-1:0] acc_q;
    logic [OW-1:0] out_q;
    logic          valid_q;
    logic [OW-1:0] root_sum;
    logic [OW-1:0] acc_d;

    // The pipe moves only when the output register is free or being drained.
    assign en      = !valid_q || ready_i;
    assign ready_o = en;
    assign out_o   = out_q;
    assign valid_o = valid_q;

    // Level 0: widen every lane to the accumulator width.
    for (gi = 0; gi < N; gi++) begin : g_ext
        if (SIGNED) begin : g_sx
            logic signed [W-1:0]  lane_s;
            logic signed [OW-1:0] lane_sx;
            assign lane_s       = in_i[gi];
            assign lane_sx      = lane_s;
            assign lane_ext[gi] = lane_sx;
        end else begin : g_zx
            assign lane_ext[gi] = OW'(in_i[gi]);
        end
    end

    // Pairwise adder levels; an odd leftover node is carried with +0.
    for (gi = 1; gi <= STAGES; gi++) begin : g_lvl
        localparam int CNT  = lvl_cnt(gi);
        localparam int PCNT = lvl_cnt(gi - 1);
        localparam int OFS  = lvl_ofs(gi);
        localparam int POFS = lvl_ofs(gi - 1);
        for (gj = 0; gj < CNT; gj++) begin : g_node
            logic [OW-1:0] lhs_d;
            logic [OW-1:0] rhs_d;
            if (gi == 1) begin : g_leaf
                assign lhs_d = lane_ext[2*gj];
                if (2*gj + 1 < PCNT) begin : g_pair
                    assign rhs_d = lane_ext[2*gj + 1];
                end else begin : g_odd
                    assign rhs_d = '0;
                end
            end else begin : g_inner
                assign lhs_d = node_q[POFS + 2*gj];
                if (2*gj + 1 < PCNT) begin : g_pair
                    assign rhs_d = node_q[POFS + 2*gj + 1];
                end else begin : g_odd
                    assign rhs_d = '0;
                end
            end

            // Tree data needs no reset: the valid bits qualify it.
            always_ff @(posedge clk_i) begin
                if (en) begin
                    node_q[OFS + gj] <= lhs_d + rhs_d;
                end
            end
        end
    end

    // Valid and first/last tags travel alongside the data of each level.
    for (gi = 1; gi <= STAGES; gi++) begin : g_tag
        logic vld_d;
        logic first_d;
        logic last_d;
        if (gi == 1) begin : g_head
            assign vld_d   = valid_i;
            assign first_d = first_i;
            assign last_d  = last_i;
        end else begin : g_body
            assign vld_d   = vld_q[gi-1];
            assign first_d = first_q[gi-1];
            assign last_d  = last_q[gi-1];
        end

        // Valid bit: cleared on reset so in-flight beats are dropped.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                vld_q[gi] <= 1'b0;
            end else if (en) begin
                vld_q[gi] <= vld_d;
            end
        end

        // Tag bits are only meaningful alongside a set valid bit.
        always_ff @(posedge clk_i) begin
            if (en) begin
                first_q[gi] <= first_d;
                last_q[gi]  <= last_d;
            end
        end
    end

    // A first beat restarts the running sum, otherwise the tree sum is added on.
    assign root_sum = node_q[ROOT];
    assign acc_d    = first_q[STAGES] ? root_sum : acc_q + root_sum;

    // Accumulate valid tree beats and publish the packet sum on the last beat.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
        end else if (en) begin
            if (vld_q[STAGES]) begin
                acc_q <= acc_d;
                if (last_q[STAGES]) begin
                    out_q   <= acc_d;
                    valid_q <= 1'b1;
                end else begin
                    valid_q <= 1'b0;
                end
            end else begin
                valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_acc_adder_tree.sv
// Bench for acc_adder_tree: a table of beats plus hand-written sequences
// for latency, bubbles, back-pressure and reset. Expected packet sums are
// queued when a last beat is accepted and checked as results drain.
module tb_acc_adder_tree;

    localparam int N  = 81;
    localparam int W  = 32;
    localparam int OW = 48;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [W-1:0]  lanes [0:N-1];
    logic          valid_in, first_in, last_in, ready_in;
    logic          ready_out, ready_out_u;
    logic          valid_out, valid_out_u;
    logic [OW-1:0] out_s, out_u;

    acc_adder_tree #(.N(N), .W(W), .OW(OW), .SIGNED(1'b1)) dut (
        .clk_i(clk), .rst_i(rst), .in_i(lanes), .valid_i(valid_in),
        .first_i(first_in), .last_i(last_in), .ready_o(ready_out),
        .out_o(out_s), .valid_o(valid_out), .ready_i(ready_in)
    );

    acc_adder_tree #(.N(N), .W(W), .OW(OW), .SIGNED(1'b0)) dut_u (
        .clk_i(clk), .rst_i(rst), .in_i(lanes), .valid_i(valid_in),
        .first_i(first_in), .last_i(last_in), .ready_o(ready_out_u),
        .out_o(out_u), .valid_o(valid_out_u), .ready_i(ready_in)
    );

    int n_vec = 0;
    int n_err = 0;
    int beat_no = 0;
    bit bp_mode = 1'b0;
    logic [OW-1:0] exp_q[$];
    logic [OW-1:0] exp_u_q[$];

    typedef struct {
        logic [W-1:0]  val;
        bit            idx;
        bit            first;
        bit            last;
        logic [OW-1:0] exp_s;
        logic [OW-1:0] exp_u;
    } vec_t;

    vec_t vecs [0:12];

    task automatic send_beat(input logic [W-1:0] val, input bit idx, input bit f, input bit l,
                             input logic [OW-1:0] es, input logic [OW-1:0] eu);
        int  guard;
        bit  done;
        guard = 0;
        done  = 1'b0;
        for (int i = 0; i < N; i++) lanes[i] = idx ? W'(i) : val;
        valid_in = 1'b1;
        first_in = f;
        last_in  = l;
        while (!done) begin
            @(negedge clk);
            if (ready_out) begin
                done = 1'b1;
                beat_no++;
                $display("beat %0d: lanes=%h idx=%0b first=%0b last=%0b accepted", beat_no, val, idx, f, l);
                if (l) begin
                    exp_q.push_back(es);
                    exp_u_q.push_back(eu);
                end
            end
            @(posedge clk);
            #1;
            guard++;
            if (!done && guard > 200) begin
                n_vec++;
                n_err++;
                $display("FAIL accept_timeout: ready_o=%0b after %0d cycles, required 1", ready_out, guard);
                done = 1'b1;
            end
        end
        valid_in = 1'b0;
        first_in = 1'b0;
        last_in  = 1'b0;
    endtask

    task automatic check_latency(input int want, input string name);
        int k;
        bit seen;
        k = 0;
        seen = 1'b0;
        while (!seen && k < 50) begin
            @(negedge clk);
            k++;
            if (valid_out) seen = 1'b1;
        end
        n_vec++;
        if (!seen || k != want) begin
            n_err++;
            $display("FAIL %s: valid_o after %0d cycles (seen=%0b), required %0d", name, k, seen, want);
        end else begin
            $display("latency %s: %0d cycles", name, k);
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || exp_u_q.size() != 0) && k < 400) begin
            @(negedge clk);
            k++;
        end
        n_vec++;
        if (exp_q.size() != 0 || exp_u_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d/%0d results outstanding, required 0/0", exp_q.size(), exp_u_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_bit(input string name, input logic act, input logic req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %b, required %b", name, act, req);
        end
    endtask

    // Output monitor: pops the scoreboard, checks hold under stall and ready_o.
    initial begin : monitor
        logic [OW-1:0] e;
        logic [OW-1:0] prev_out;
        bit prev_stall;
        prev_stall = 1'b0;
        prev_out   = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    n_vec++;
                    if (!valid_out || out_s !== prev_out) begin
                        n_err++;
                        $display("FAIL stall_hold: valid_o=%0b out_o=%h, required 1 and %h", valid_out, out_s, prev_out);
                    end
                end
                if (bp_mode) begin
                    n_vec++;
                    if (ready_out !== (!valid_out || ready_in)) begin
                        n_err++;
                        $display("FAIL ready_o: got %b, required %b", ready_out, (!valid_out || ready_in));
                    end
                end
                if (valid_out && ready_in) begin
                    n_vec++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_result: out_o=%h, required no result", out_s);
                    end else begin
                        e = exp_q.pop_front();
                        if (out_s !== e) begin
                            n_err++;
                            $display("FAIL result_signed: out_o=%h, required %h", out_s, e);
                        end else begin
                            $display("result signed: out_o=%h", out_s);
                        end
                    end
                end
                if (valid_out_u && ready_in) begin
                    n_vec++;
                    if (exp_u_q.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_result_u: out_o=%h, required no result", out_u);
                    end else begin
                        e = exp_u_q.pop_front();
                        if (out_u !== e) begin
                            n_err++;
                            $display("FAIL result_unsigned: out_o=%h, required %h", out_u, e);
                        end else begin
                            $display("result unsigned: out_o=%h", out_u);
                        end
                    end
                end
                prev_stall = valid_out && !ready_in;
                prev_out   = out_s;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{'0,            1'b1, 1'b1, 1'b1, 48'd3240,           48'd3240};
        vecs[1]  = '{32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1, 48'hFFFF_FFFF_FFAF, 48'h0050_FFFF_FFAF};
        vecs[2]  = '{32'd1,         1'b0, 1'b1, 1'b0, '0,                 '0};
        vecs[3]  = '{32'd2,         1'b0, 1'b0, 1'b0, '0,                 '0};
        vecs[4]  = '{32'd3,         1'b0, 1'b0, 1'b1, 48'd486,            48'd486};
        vecs[5]  = '{32'd5,         1'b0, 1'b1, 1'b1, 48'd405,            48'd405};
        vecs[6]  = '{32'd9,         1'b0, 1'b1, 1'b0, '0,                 '0};
        vecs[7]  = '{32'd4,         1'b0, 1'b1, 1'b1, 48'd324,            48'd324};
        vecs[8]  = '{32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1, 48'h0028_7FFF_FFAF, 48'h0028_7FFF_FFAF};
        vecs[9]  = '{32'h8000_0000, 1'b0, 1'b1, 1'b1, 48'hFFD7_8000_0000, 48'h0028_8000_0000};
        vecs[10] = '{32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, '0,                 '0};
        vecs[11] = '{32'd1,         1'b0, 1'b0, 1'b1, 48'd0,              48'h0051_0000_0000};
        vecs[12] = '{32'd10,        1'b0, 1'b0, 1'b1, 48'd810,            48'h0051_0000_032A};

        rst = 1'b1;
        valid_in = 1'b0;
        first_in = 1'b0;
        last_in = 1'b0;
        ready_in = 1'b1;
        for (int i = 0; i < N; i++) lanes[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check_bit("reset_valid_o", valid_out, 1'b0);
        check_bit("reset_ready_o", ready_out, 1'b1);
        n_vec++;
        if (out_s !== '0 || out_u !== '0) begin
            n_err++;
            $display("FAIL reset_out_o: got %h/%h, required 0/0", out_s, out_u);
        end
        @(posedge clk);
        #1;

        // Table of back-to-back beats
        for (int v = 0; v <= 12; v++) begin
            send_beat(vecs[v].val, vecs[v].idx, vecs[v].first, vecs[v].last, vecs[v].exp_s, vecs[v].exp_u);
        end
        drain();

        // Single beat: latency 8, then a single valid cycle
        send_beat('0, 1'b1, 1'b1, 1'b1, 48'd3240, 48'd3240);
        check_latency(8, "single_beat");
        @(negedge clk);
        check_bit("single_beat_valid_drop", valid_out, 1'b0);
        drain();

        // Three-beat accumulation: result 8 cycles after the last beat
        send_beat(32'd1, 1'b0, 1'b1, 1'b0, '0, '0);
        send_beat(32'd2, 1'b0, 1'b0, 1'b0, '0, '0);
        send_beat(32'd3, 1'b0, 1'b0, 1'b1, 48'd486, 48'd486);
        check_latency(8, "accumulate");
        drain();

        // Bubbles inside a packet
        send_beat(32'd5, 1'b0, 1'b1, 1'b0, '0, '0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        send_beat(32'd5, 1'b0, 1'b0, 1'b1, 48'd810, 48'd810);
        check_latency(8, "bubbles");
        drain();

        // Back-pressure with random ready_i
        bp_mode = 1'b1;
        fork
            begin
                for (int k = 1; k <= 20; k++) begin
                    send_beat(W'(k), 1'b0, 1'b1, 1'b1, OW'(81 * k), OW'(81 * k));
                end
            end
            begin
                repeat (250) begin
                    @(posedge clk);
                    #1;
                    ready_in = 1'($urandom_range(0, 1));
                end
            end
        join
        ready_in = 1'b1;
        drain();
        bp_mode = 1'b0;

        // Reset while a result is stalled on the output
        ready_in = 1'b0;
        send_beat(32'd3, 1'b0, 1'b1, 1'b1, 48'd243, 48'd243);
        check_latency(8, "stalled_result");
        check_bit("stalled_ready_o", ready_out, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        exp_u_q.delete();
        ready_in = 1'b1;
        @(negedge clk);
        check_bit("reset_drops_valid_o", valid_out, 1'b0);
        check_bit("reset_ready_o_after", ready_out, 1'b1);
        n_vec++;
        if (out_s !== '0) begin
            n_err++;
            $display("FAIL reset_clears_out_o: got %h, required 0", out_s);
        end
        @(posedge clk);
        #1;

        // Reset mid-packet, then a no-first beat and a single-beat packet
        send_beat(32'd7, 1'b0, 1'b1, 1'b0, '0, '0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_bit("midpkt_reset_valid_o", valid_out, 1'b0);
        @(posedge clk);
        #1;
        send_beat(32'd2, 1'b0, 1'b0, 1'b1, 48'd162, 48'd162);
        send_beat(32'd1, 1'b0, 1'b1, 1'b1, 48'd81, 48'd81);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/acc_adder_tree.md
# acc_adder_tree

Parametrised, fully pipelined reduction tree that sums N W-bit lanes per beat and can optionally accumulate the tree sums over a multi-beat packet before presenting one result. It is the general successor to the fixed six-level tree in the convolution accelerator datapath. Depth, output width and signedness are derived from parameters. It adds valid/ready flow control with back-pressure and first/last-tagged accumulation for multi-channel kernels. It sits between the multiplier array and the result writeback path.

## Interface
- N, 81, number of input lanes; N ≥ 1
- W, 32, input lane width in bits
- OW, 48, output and accumulator width; OW ≥ W + $clog2(N)
- SIGNED, 1, 1 = lanes sign-extended to OW, 0 = zero-extended
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  synchronous, active-high reset
- in_i  in  N×W (unpacked array [0:N-1])  lane operands
- valid_i  in  1  beat present on in_i/first_i/last_i
- first_i  in  1  beat opens a packet; the accumulator restarts at this beat's sum
- last_i  in  1  beat closes a packet; the result is emitted after it
- ready_o  out  1  beat accepted on an edge where valid_i && ready_o
- out_o  out  OW  packet sum
- valid_o  out  1  out_o holds a result
- ready_i  in  1  downstream accepts out_o on an edge where valid_o && ready_i

## Operation
- STAGES = max(1, $clog2(N)). Tree level k has ceil(N/2^k) registers.
- Each level register holds the sum of a pair from the previous level. An odd leftover element is passed through with +0.
- Level 0 is in_i, extended to OW per SIGNED. All additions wrap modulo 2^OW, with no saturation and no overflow flag.
- Each level carries a valid bit, together with first/last tag bits.
- Global enable: en = !valid_o || ready_i. ready_o = en, combinational from valid_o and ready_i only.
- When en = 0, every level, the accumulator, out_o and valid_o hold.
- When en = 1, all levels advance. A level loaded from an invalid stage gets valid = 0, i.e. a bubble.
- Final stage, on en with a valid tree beat (sum S):
  - acc_q <= first ? S : acc_q + S
  - if last: out_o <= (first ? S : acc_q + S) and valid_o <= 1
- On en with no valid final beat, or a valid beat that is not last: valid_o <= 0. out_o keeps its value.
- Bubbles never modify acc_q.
- first and last on the same beat form a single-beat packet, with result S.
- A beat without first, arriving after reset and before any first, accumulates onto acc_q = 0.
- A beat with first arriving mid-packet discards the partial sum.
- Beat count per packet is unbounded. No length checking is done.
- Reset: all valid bits = 0, valid_o = 0, out_o = 0, acc_q = 0. Data registers inside the tree need no reset.
- Reset mid-packet drops all in-flight beats and the partial sum. The first output after reset belongs to a packet fully accepted after reset.

## Timing
- Latency LAT = STAGES + 1 edges with no stall.
  - A last beat accepted at edge t gives valid_o = 1 in the cycle after edge t + STAGES.
  - For N = 81: STAGES = 7, LAT = 8.
  - For N = 1: STAGES = 1, LAT = 2.
- Throughput is one beat per cycle while ready_i = 1.
- Stall: if valid_o && !ready_i, then ready_o = 0 in that same cycle. in_i is ignored and the pipeline is frozen without loss.
- out_o and valid_o are registered. out_o is stable while valid_o && !ready_i.
- Reset is taken on the edge regardless of en, with ready_o = 1 in the cycle after reset.

## Test plan
- Single beat, N=81, W=32, SIGNED=1, lanes i = i, first=last=1 -> valid_o exactly 8 cycles later with out_o = 3240, then valid_o = 0.
- Signed wrap: all 81 lanes = 32'hFFFFFFFF, SIGNED=1 -> out_o = -81 (48'hFFFF_FFFF_FFAF). With SIGNED=0 -> out_o = 81×(2^32−1) = 48'h50_FFFF_FFAF.
- Accumulation: 3 back-to-back beats with all lanes = 1, 2, 3, tagged first / none / last -> one result of 486, 10 cycles after the first beat, with no intermediate valid_o.
- Back-pressure: stream 20 single-beat packets of all lanes = k (k = 1..20) and toggle ready_i 0/1 randomly -> 20 results of 81k in order, none lost or duplicated, ready_o = 0 exactly in the stalled cycles.
- Bubbles between beats of one packet (valid_i low 3 cycles between first and last, lanes = 5 each) -> out_o = 810, with valid_o delayed only by the bubbles.
- Reset mid-packet: assert rst_i after first beat (lanes = 7) -> valid_o = 0 next cycle. A subsequent first+last beat of lanes = 1 gives out_o = 81, not 648.
